// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RISC-V immediate generator with 2-entry skid buffer
module imm_gen_pipe #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } entry_t;

    state_t state, state_n;
    entry_t r0, r1, d_entry;

    logic load_r0_in;
    logic load_r1_in;
    logic move_r1_r0;
    logic accept;
    logic pop;

    // Decode fields; every immediate is formed at 64 bits and truncated to XLEN
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        sgn;
    logic        is_shift;
    logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [63:0] imm64;
    logic [2:0]  d_fmt;
    logic        d_illegal;

    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign sgn      = in_instr[31];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    assign imm_i = {{52{sgn}}, in_instr[31:20]};
    assign imm_s = {{52{sgn}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{51{sgn}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {{32{sgn}}, in_instr[31:12], 12'b0};
    assign imm_j = {{43{sgn}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    // Opcode decode: select format and immediate, flag unrecognised opcodes
    always_comb begin
        imm64     = 64'd0;
        d_fmt     = FMT_NONE;
        d_illegal = 1'b0;
        case (opcode)
            7'b0010011: begin
                if (is_shift) begin
                    d_fmt = FMT_SHAMT;
                    if (XLEN == 64) begin
                        imm64 = {58'd0, in_instr[25:20]};
                    end else begin
                        imm64 = {59'd0, in_instr[24:20]};
                    end
                end else begin
                    d_fmt = FMT_I;
                    imm64 = imm_i;
                end
            end
            7'b0000011, 7'b1100111, 7'b1110011: begin
                d_fmt = FMT_I;
                imm64 = imm_i;
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    if (is_shift) begin
                        d_fmt = FMT_SHAMT;
                        imm64 = {59'd0, in_instr[24:20]};
                    end else begin
                        d_fmt = FMT_I;
                        imm64 = imm_i;
                    end
                end else begin
                    d_illegal = 1'b1;
                end
            end
            7'b0100011: begin
                d_fmt = FMT_S;
                imm64 = imm_s;
            end
            7'b1100011: begin
                d_fmt = FMT_B;
                imm64 = imm_b;
            end
            7'b0110111, 7'b0010111: begin
                d_fmt = FMT_U;
                imm64 = imm_u;
            end
            7'b1101111: begin
                d_fmt = FMT_J;
                imm64 = imm_j;
            end
            7'b0110011: begin
                d_fmt = FMT_NONE;
            end
            7'b0111011: begin
                d_illegal = (XLEN != 64);
            end
            default: begin
                d_illegal = 1'b1;
            end
        endcase
    end

    assign d_entry.imm     = imm64[XLEN-1:0];
    assign d_entry.fmt     = d_fmt;
    assign d_entry.tag     = in_tag;
    assign d_entry.illegal = d_illegal;

    // Handshake strobes; in_ready depends on registered occupancy only
    assign in_ready  = (state != ST_TWO);
    assign out_valid = (state != ST_EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Occupancy state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_n;
        end
    end

    // Next occupancy and register load selects
    always_comb begin
        state_n    = state;
        load_r0_in = 1'b0;
        load_r1_in = 1'b0;
        move_r1_r0 = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    load_r0_in = 1'b1;
                    state_n    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    load_r0_in = 1'b1;
                end else if (accept) begin
                    load_r1_in = 1'b1;
                    state_n    = ST_TWO;
                end else if (pop) begin
                    state_n    = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    move_r1_r0 = 1'b1;
                    state_n    = ST_ONE;
                end
            end
            default: begin
                state_n = ST_EMPTY;
            end
        endcase
    end

    // Output register R0 and skid register R1
    always_ff @(posedge clk) begin
        if (reset) begin
            r0 <= '0;
            r1 <= '0;
        end else begin
            if (load_r0_in) begin
                r0 <= d_entry;
            end else if (move_r1_r0) begin
                r0 <= r1;
            end
            if (load_r1_in) begin
                r1 <= d_entry;
            end
        end
    end

    // Saturating count of accepted illegal opcodes
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_cnt <= '0;
        end else if (accept && d_illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

    assign out_imm     = r0.imm;
    assign out_fmt     = r0.fmt;
    assign out_tag     = r0.tag;
    assign out_illegal = r0.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe
module tb_imm_gen_pipe;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [31:0] tag;
        logic        ill;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr, in_tag, out_tag;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic [15:0] illegal_cnt;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_illegal;
    logic [31:0] b_in_instr, b_in_tag, b_out_tag, b_out_imm;
    logic [2:0]  b_out_fmt;
    logic [1:0]  b_illegal_cnt;

    int   n_vec = 0;
    int   n_err = 0;
    int   exp_cnt = 0;
    int   b_cnt = 0;
    logic rand_bp = 1'b0;

    logic [63:0] cur_imm;
    logic [2:0]  cur_fmt;
    logic        cur_ill;
    sb_t         sb_q[$];
    vec_t        vecs[17];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
        .out_tag(out_tag), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
    );

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .CNT_W(2)) dut32 (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(1'b1), .out_imm(b_out_imm), .out_fmt(b_out_fmt),
        .out_tag(b_out_tag), .out_illegal(b_out_illegal), .illegal_cnt(b_illegal_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: pop/compare on output transfer, push expectation on input transfer
    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
            exp_cnt = 0;
        end else begin
            if (out_valid && out_ready) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: got tag %h with nothing outstanding", out_tag);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    if ({out_imm, out_fmt, out_tag, out_illegal} !== {e.imm, e.fmt, e.tag, e.ill}) begin
                        n_err++;
                        $display("FAIL sb_out: got imm %h fmt %0d tag %h ill %b expected imm %h fmt %0d tag %h ill %b",
                                 out_imm, out_fmt, out_tag, out_illegal, e.imm, e.fmt, e.tag, e.ill);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back('{cur_imm, cur_fmt, in_tag, cur_ill});
                if (cur_ill && exp_cnt < 65535) exp_cnt++;
            end
        end
    end

    // Random consumer backpressure during the stress phase
    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic setin(input vec_t v, input logic [31:0] tag);
        in_instr = v.instr;
        in_tag   = tag;
        cur_imm  = v.imm;
        cur_fmt  = v.fmt;
        cur_ill  = v.ill;
        in_valid = 1'b1;
    endtask

    task automatic send(input vec_t v, input logic [31:0] tag);
        logic acc;
        acc = 1'b0;
        setin(v, tag);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got no accept for tag %h expected accept within 100 cycles", tag);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send32(input logic [31:0] instr, input logic [31:0] imm, input logic [2:0] fmt, input logic ill);
        b_in_instr = instr;
        b_in_tag   = instr;
        b_in_valid = 1'b1;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        if (ill && b_cnt < 3) b_cnt++;
        chk("x32_valid", 64'(b_out_valid), 64'd1);
        chk("x32_imm", 64'(b_out_imm), 64'(imm));
        chk("x32_fmt_ill", 64'({b_out_fmt, b_out_illegal}), 64'({fmt, ill}));
        chk("x32_cnt", 64'(b_illegal_cnt), 64'(b_cnt));
    endtask

    initial begin
        vecs[0]  = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0};
        vecs[1]  = '{32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0};
        vecs[2]  = '{32'h800002B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0};
        vecs[3]  = '{32'h0010006F, 64'h0000_0000_0000_0800, 3'd5, 1'b0};
        vecs[4]  = '{32'h43F0D093, 64'h0000_0000_0000_003F, 3'd6, 1'b0};
        vecs[5]  = '{32'h0000007F, 64'h0000_0000_0000_0000, 3'd0, 1'b1};
        vecs[6]  = '{32'h002081B3, 64'h0000_0000_0000_0000, 3'd0, 1'b0};
        vecs[7]  = '{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0};
        vecs[8]  = '{32'h00001017, 64'h0000_0000_0000_1000, 3'd4, 1'b0};
        vecs[9]  = '{32'h02009093, 64'h0000_0000_0000_0020, 3'd6, 1'b0};
        vecs[10] = '{32'hFFF0009B, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0};
        vecs[11] = '{32'h0210909B, 64'h0000_0000_0000_0001, 3'd6, 1'b0};
        vecs[12] = '{32'h0020803B, 64'h0000_0000_0000_0000, 3'd0, 1'b0};
        vecs[13] = '{32'h80002083, 64'hFFFF_FFFF_FFFF_F800, 3'd1, 1'b0};
        vecs[14] = '{32'h00000073, 64'h0000_0000_0000_0000, 3'd1, 1'b0};
        vecs[15] = '{32'h000080E7, 64'h0000_0000_0000_0000, 3'd1, 1'b0};
        vecs[16] = '{32'hFFDFF0EF, 64'hFFFF_FFFF_FFFF_FFFC, 3'd5, 1'b0};

        reset      = 1'b1;
        in_valid   = 1'b0;
        in_instr   = 32'd0;
        in_tag     = 32'd0;
        out_ready  = 1'b1;
        b_in_valid = 1'b0;
        b_in_instr = 32'd0;
        b_in_tag   = 32'd0;
        cur_imm    = 64'd0;
        cur_fmt    = 3'd0;
        cur_ill    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_imm", out_imm, 64'd0);
        chk("rst_fmt_tag_ill", 64'({out_fmt, out_tag, out_illegal}), 64'd0);
        chk("rst_cnt", 64'(illegal_cnt), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // XLEN=32, CNT_W=2 build, including counter saturation
        send32(32'h800002B7, 32'h8000_0000, 3'd4, 1'b0);
        send32(32'h0000009B, 32'h0, 3'd0, 1'b1);
        send32(32'h43F0D093, 32'h0000_001F, 3'd6, 1'b0);
        send32(32'h0020803B, 32'h0, 3'd0, 1'b1);
        send32(32'hFFF00093, 32'hFFFF_FFFF, 3'd1, 1'b0);
        for (int i = 0; i < 5; i++) send32(32'h0000007F, 32'h0, 3'd0, 1'b1);

        // Single-cycle latency into an empty block
        send(vecs[0], 32'h11);
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("lat_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("lat_fmt", 64'(out_fmt), 64'd1);
        idle(2);

        // Illegal opcode bumps the counter 0 -> 1
        chk("cnt_before", 64'(illegal_cnt), 64'd0);
        send(vecs[5], 32'h22);
        in_valid = 1'b0;
        chk("ill_flag", 64'({out_illegal, out_fmt}), 64'({1'b1, 3'd0}));
        chk("cnt_after", 64'(illegal_cnt), 64'd1);
        idle(2);

        // Table pass, streaming with out_ready held high
        for (int i = 0; i < 17; i++) send(vecs[i], 32'(100 + i));
        idle(3);
        chk("cnt_table", 64'(illegal_cnt), 64'(exp_cnt));

        // Stress: random input gaps and random consumer backpressure
        rand_bp = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 17; i++) begin
                if ($urandom_range(0, 2) == 0) idle(1);
                send(vecs[$urandom_range(0, 16)], 32'(1000 + r * 17 + i));
            end
        end
        in_valid = 1'b0;
        rand_bp  = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        for (int k = 0; k < 50 && sb_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
        chk("cnt_stress", 64'(illegal_cnt), 64'(exp_cnt));
        idle(2);

        // Backpressure: three back-to-back offers, skid holds two
        out_ready = 1'b0;
        setin(vecs[0], 32'd1);
        @(posedge clk); #1;
        setin(vecs[1], 32'd2);
        @(posedge clk); #1;
        setin(vecs[2], 32'd3);
        chk("bp_full_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("bp_hold_ready", 64'(in_ready), 64'd0);
        chk("bp_hold_tag", 64'({out_valid, out_tag}), 64'({1'b1, 32'd1}));
        chk("bp_hold_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_stream_2", 64'({out_valid, out_tag}), 64'({1'b1, 32'd2}));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_stream_3", 64'({out_valid, out_tag}), 64'({1'b1, 32'd3}));
        @(posedge clk); #1;
        chk("bp_done", 64'(out_valid), 64'd0);

        // Reset while two entries are held
        out_ready = 1'b0;
        setin(vecs[5], 32'h51);
        @(posedge clk); #1;
        setin(vecs[0], 32'h52);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("two_full", 64'(in_ready), 64'd0);
        chk("two_cnt", 64'(illegal_cnt), 64'(exp_cnt));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_cnt", 64'(illegal_cnt), 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("no_stale", 64'(out_valid), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
